// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS encodings, default bus widths, arbiter
// state type and a constant clog2 helper for sizing index/counter fields.
package ahb_pkg;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // PARK: default master holds the bus with nobody requesting.
    // OWN : a requesting master has been granted.
    typedef enum logic [0:0] {
        ST_PARK = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so that derived fields are never zero width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last+1 upward (wrapping) and
// returns the first requester; the index equal to 'last' is tried last.
module rr_pick
    import ahb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    int   cand_s;
    logic hit_s;
    logic found_s;

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        index_o = '0;
        found_s = 1'b0;
        cand_s  = 0;
        hit_s   = 1'b0;
        for (int off = 1; off <= N; off++) begin
            cand_s  = (int'(last_i) + off) % N;
            hit_s   = !found_s && req_i[cand_s[IDX_W-1:0]];
            index_o = hit_s ? cand_s[IDX_W-1:0] : index_o;
            found_s = found_s | hit_s;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin arbiter and master multiplexer. Grants change only at
// transfer boundaries (HREADY high, owner not mid-burst), and a hold counter
// forces the owner to yield after MAX_HOLD accepted transfers when others wait.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int  NUM_MASTERS    = 4,
    parameter int  ADDR_W         = AHB_ADDR_W,
    parameter int  DATA_W         = AHB_DATA_W,
    parameter int  DEFAULT_MASTER = 0,
    parameter int  MAX_HOLD       = 16,
    localparam int IDX_W          = clog2(NUM_MASTERS),
    localparam int CNT_W          = clog2(MAX_HOLD + 1)
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_MASTERS-1:0]        m_hbusreq,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
    input  logic [NUM_MASTERS*2-1:0]      m_htrans,
    input  logic [NUM_MASTERS-1:0]        m_hwrite,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
    output logic [NUM_MASTERS-1:0]        m_hgrant,
    output logic [ADDR_W-1:0]             HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [DATA_W-1:0]             HWDATA,
    input  logic                          HREADY,
    output logic [IDX_W-1:0]              HMASTER,
    output logic [IDX_W-1:0]              HMASTER_D
);

    localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
    localparam logic [CNT_W-1:0]       MAX_CNT   = CNT_W'(MAX_HOLD);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    // Registered state
    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       hmaster_q, hmaster_d;
    logic [IDX_W-1:0]       dmaster_q, dmaster_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;

    // Per-master views of the flattened input buses
    logic [ADDR_W-1:0] haddr_arr  [NUM_MASTERS];
    logic [1:0]        htrans_arr [NUM_MASTERS];
    logic [DATA_W-1:0] hwdata_arr [NUM_MASTERS];

    // Decision signals
    logic [1:0]       owner_trans_s;
    logic             owner_req_s;
    logic             arb_point_s;
    logic             xfer_s;
    logic             other_req_s;
    logic             hold_limit_s;
    logic             rearb_s;
    logic             any_req_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [IDX_W-1:0] next_owner_s;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_split
        assign haddr_arr[g]  = m_haddr[g*ADDR_W +: ADDR_W];
        assign htrans_arr[g] = m_htrans[g*2 +: 2];
        assign hwdata_arr[g] = m_hwdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (m_hbusreq),
        .last_i  (hmaster_q),
        .valid_o (any_req_s),
        .index_o (pick_idx_s)
    );

    // Boundary detection, yield conditions and the candidate next owner.
    always_comb begin
        owner_trans_s = htrans_arr[hmaster_q];
        owner_req_s   = m_hbusreq[hmaster_q];
        arb_point_s   = HREADY && ((owner_trans_s == HTRANS_IDLE) ||
                                   (owner_trans_s == HTRANS_NONSEQ));
        xfer_s        = HREADY && ((owner_trans_s == HTRANS_NONSEQ) ||
                                   (owner_trans_s == HTRANS_SEQ));
        other_req_s   = |(m_hbusreq & ~grant_q);
        hold_limit_s  = (hold_cnt_q >= MAX_CNT);
        rearb_s       = !owner_req_s || (hold_limit_s && other_req_s);
        if (rearb_s) begin
            next_owner_s = pick_idx_s;
        end else begin
            next_owner_s = hmaster_q;
        end
    end

    // Park/own state machine choosing the next address-phase owner.
    always_comb begin
        state_d   = state_q;
        hmaster_d = hmaster_q;
        case (state_q)
            ST_PARK: begin
                if (arb_point_s && any_req_s) begin
                    state_d   = ST_OWN;
                    hmaster_d = next_owner_s;
                end else begin
                    state_d   = ST_PARK;
                    hmaster_d = hmaster_q;
                end
            end
            ST_OWN: begin
                if (arb_point_s && !any_req_s) begin
                    state_d   = ST_PARK;
                    hmaster_d = DEF_IDX;
                end else if (arb_point_s) begin
                    state_d   = ST_OWN;
                    hmaster_d = next_owner_s;
                end else begin
                    state_d   = ST_OWN;
                    hmaster_d = hmaster_q;
                end
            end
            default: begin
                state_d   = ST_PARK;
                hmaster_d = DEF_IDX;
            end
        endcase
    end

    // One-hot grant decode of the next owner.
    always_comb begin
        grant_d = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hmaster_d == IDX_W'(i)) begin
                grant_d[i] = 1'b1;
            end else begin
                grant_d[i] = 1'b0;
            end
        end
    end

    // Data-phase owner follows the address-phase owner whenever a phase completes.
    always_comb begin
        if (HREADY) begin
            dmaster_d = hmaster_q;
        end else begin
            dmaster_d = dmaster_q;
        end
    end

    // Hold counter: cleared on ownership change, saturating count of accepted transfers.
    always_comb begin
        if (hmaster_d != hmaster_q) begin
            hold_cnt_d = '0;
        end else if (xfer_s && (hold_cnt_q < MAX_CNT)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_PARK;
            grant_q    <= DEF_GRANT;
            hmaster_q  <= DEF_IDX;
            dmaster_q  <= DEF_IDX;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            hmaster_q  <= hmaster_d;
            dmaster_q  <= dmaster_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign m_hgrant  = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = dmaster_q;
    assign HADDR     = haddr_arr[hmaster_q];
    assign HTRANS    = htrans_arr[hmaster_q];
    assign HWRITE    = m_hwrite[hmaster_q];
    assign HWDATA    = hwdata_arr[dmaster_q];

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter (4 masters, hold limit 4): directed vector table,
// hand-written multi-cycle sequences, then randomized traffic against a model.
module tb_ahb_rr_arbiter;
    import ahb_pkg::*;

    localparam int N    = 4;
    localparam int MAXH = 4;
    localparam int DEF  = 0;

    logic          HCLK;
    logic          HRESET;
    logic [N-1:0]  m_hbusreq;
    logic [N*32-1:0] m_haddr;
    logic [N*2-1:0]  m_htrans;
    logic [N-1:0]  m_hwrite;
    logic [N*32-1:0] m_hwdata;
    logic [N-1:0]  m_hgrant;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic [1:0]    HMASTER;
    logic [1:0]    HMASTER_D;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_W         (32),
        .DATA_W         (32),
        .DEFAULT_MASTER (DEF),
        .MAX_HOLD       (MAXH)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .m_hbusreq (m_hbusreq),
        .m_haddr   (m_haddr),
        .m_htrans  (m_htrans),
        .m_hwrite  (m_hwrite),
        .m_hwdata  (m_hwdata),
        .m_hgrant  (m_hgrant),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: who owns the address phase, who owns the data phase,
    // and how many transfers the owner has had accepted since it was granted.
    int m_owner  = DEF;
    int m_downer = DEF;
    int m_cnt    = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] trans;
        logic       rdy;
        logic [3:0] exp_grant;
        logic [1:0] exp_hm;
        logic [1:0] exp_hmd;
        logic       chk_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] trans_of(input int o);
        logic [7:0] t;
        t = m_htrans;
        return t[2*o +: 2];
    endfunction

    function automatic logic [31:0] addr_of(input int o);
        logic [127:0] a;
        a = m_haddr;
        return a[32*o +: 32];
    endfunction

    function automatic logic [31:0] wdata_of(input int o);
        logic [127:0] d;
        d = m_hwdata;
        return d[32*o +: 32];
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [1:0] tr;
        logic [3:0] rq;
        int  nxt;
        bit  arb;
        bit  others;
        bit  found;
        if (HRESET) begin
            m_owner  = DEF;
            m_downer = DEF;
            m_cnt    = 0;
        end else begin
            rq  = m_hbusreq;
            tr  = trans_of(m_owner);
            arb = HREADY && (tr == HTRANS_IDLE || tr == HTRANS_NONSEQ);
            nxt = m_owner;
            if (arb) begin
                others = 0;
                for (int i = 0; i < N; i++) begin
                    if (i != m_owner && rq[i]) others = 1;
                end
                if (!rq[m_owner] || (m_cnt >= MAXH && others)) begin
                    nxt   = DEF;
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && rq[(m_owner + k) % N]) begin
                            nxt   = (m_owner + k) % N;
                            found = 1;
                        end
                    end
                end
            end
            if (HREADY) m_downer = m_owner;
            if (nxt != m_owner) m_cnt = 0;
            else if (HREADY && (tr == HTRANS_NONSEQ || tr == HTRANS_SEQ) && m_cnt < MAXH) m_cnt++;
            m_owner = nxt;
        end
    endtask

    // Clock one edge, then compare every output against the model.
    task automatic step();
        logic [3:0] g;
        model_edge();
        @(posedge HCLK);
        #1;
        cyc++;
        g = 4'b0001 << m_owner;
        check("m_hgrant",  {60'd0, m_hgrant}, {60'd0, g});
        check("HMASTER",   {62'd0, HMASTER},  64'(m_owner));
        check("HMASTER_D", {62'd0, HMASTER_D}, 64'(m_downer));
        check("HADDR",     {32'd0, HADDR},  {32'd0, addr_of(m_owner)});
        check("HTRANS",    {62'd0, HTRANS}, {62'd0, trans_of(m_owner)});
        check("HWRITE",    {63'd0, HWRITE}, {63'd0, m_hwrite[m_owner]});
        check("HWDATA",    {32'd0, HWDATA}, {32'd0, wdata_of(m_downer)});
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic [7:0] tr, input logic rdy);
        HRESET    = rst;
        m_hbusreq = req;
        m_htrans  = tr;
        HREADY    = rdy;
    endtask

    initial begin
        logic [1:0] ws_exp [8];
        logic [7:0] ws_tr  [8];
        logic       ws_rdy [8];
        logic [3:0] ws_req [8];

        HRESET    = 1'b1;
        m_hbusreq = 4'b0000;
        m_htrans  = 8'h00;
        HREADY    = 1'b1;
        m_haddr   = {32'h0000_3000, 32'h0000_0010, 32'h0000_1000, 32'h0000_0000};
        m_hwrite  = 4'b0100;
        m_hwdata  = {32'hA000_0003, 32'hDEAD_BEEF, 32'hA000_0001, 32'hA000_0000};
        #2;

        // Reset, single request, round robin 0->1->3->0, hold limit.
        vecs.push_back('{1'b1, 4'b0000, 8'b0000_0000, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 4'b0000, 8'b0000_0000, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 4'b0100, 8'b0000_0000, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 4'b0100, 8'b0010_0000, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b1});
        vecs.push_back('{1'b1, 4'b0000, 8'b0000_0000, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 4'b1011, 8'b0000_0010, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 4'b1010, 8'b0000_0000, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 4'b1010, 8'b0000_1000, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0});
        vecs.push_back('{1'b0, 4'b1001, 8'b0000_0000, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0});
        vecs.push_back('{1'b0, 4'b1001, 8'b1000_0000, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0});
        vecs.push_back('{1'b0, 4'b0001, 8'b0000_0000, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0});
        // Master 0 streams NONSEQ while master 3 waits; the limit is seen at
        // the arbitration point after the counter reaches 4.
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0, 4'b1001, 8'b0000_0010, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 4'b1001, 8'b0000_0010, 1'b1, 4'b1000, 2'd3, 2'd0, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].trans, vecs[i].rdy);
            step();
            check("vec_grant", {60'd0, m_hgrant}, {60'd0, vecs[i].exp_grant});
            check("vec_hmaster", {62'd0, HMASTER}, {62'd0, vecs[i].exp_hm});
            check("vec_hmaster_d", {62'd0, HMASTER_D}, {62'd0, vecs[i].exp_hmd});
            if (vecs[i].chk_wd) check("vec_hwdata", {32'd0, HWDATA}, 64'h0000_0000_DEAD_BEEF);
            if (vecs[i].rst) check("vec_hold_cnt", 64'(dut.hold_cnt_q), 64'd0);
        end

        // Wait states inside a master 1 burst while master 2 requests.
        drive(1'b1, 4'b0000, 8'h00, 1'b1); step();
        drive(1'b0, 4'b0010, 8'h00, 1'b1); step();
        check("ws_own1", {62'd0, HMASTER}, 64'd1);
        ws_tr  = '{8'b0000_1000, 8'b0000_1100, 8'b0000_1100, 8'b0000_1100,
                   8'b0000_1100, 8'b0000_1100, 8'b0000_1100, 8'b0000_0000};
        ws_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ws_req = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100};
        ws_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, ws_req[i], ws_tr[i], ws_rdy[i]);
            step();
            check("ws_hmaster", {62'd0, HMASTER}, {62'd0, ws_exp[i]});
        end

        // Reset in the middle of a master 2 burst.
        drive(1'b0, 4'b0100, 8'b0010_0000, 1'b1); step();
        drive(1'b0, 4'b0100, 8'b0011_0000, 1'b1); step();
        check("mid_hold_cnt", 64'(dut.hold_cnt_q), 64'd2);
        check("mid_hmaster_d", {62'd0, HMASTER_D}, 64'd2);
        drive(1'b1, 4'b0100, 8'b0011_0000, 1'b1); step();
        check("rst_grant", {60'd0, m_hgrant}, 64'b0001);
        check("rst_hmaster_d", {62'd0, HMASTER_D}, 64'd0);
        check("rst_hold_cnt", 64'(dut.hold_cnt_q), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] rq;
            logic [7:0] tr;
            for (int i = 0; i < N; i++) begin
                rq[i]        = ($urandom_range(0, 4) != 0);
                tr[2*i +: 2] = 2'($urandom_range(0, 3));
            end
            m_haddr  = {$urandom, $urandom, $urandom, $urandom};
            m_hwdata = {$urandom, $urandom, $urandom, $urandom};
            m_hwrite = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 49) == 0), rq, tr, ($urandom_range(0, 3) != 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
